// File: rtl/button_if.sv
// Pad inputs and conditioned button outputs for the button conditioner.
// master = conditioner side, slave = consumer/stimulus side.
interface button_if;
   logic [6:0] btn_raw;
   logic       up_button;
   logic       down_button;
   logic       left_button;
   logic       right_button;
   logic       start_button;
   logic       a_button;
   logic       b_button;
   logic [6:0] btn_held;

   modport master (
      input  btn_raw,
      output up_button, down_button, left_button, right_button,
      output start_button, a_button, b_button, btn_held
   );

   modport slave (
      output btn_raw,
      input  up_button, down_button, left_button, right_button,
      input  start_button, a_button, b_button, btn_held
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects seven game buttons into press pulses.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat on the four direction buttons.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input logic      clk,
   input logic      reset,
   button_if.master btn
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
      $error("button_conditioner: invalid debounce/repeat parameters");
   end

   logic [6:0]    pressed_raw;
   logic [6:0]    sync_p0;
   logic [6:0]    sync_p1;
   logic [6:0]    held_p2;
   logic [6:0]    held_d_p2;
   logic [6:0]    pulse_p3;
   logic [6:0]    fire_vec;
   logic [CW-1:0] db_cnt [7];

   assign pressed_raw = ACTIVE_LOW ? ~btn.btn_raw : btn.btn_raw;

   // Stage p0/p1: two-flop synchronizer on the normalised pressed levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= pressed_raw;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p2: per-button debounce; a level is accepted after DEBOUNCE_CYCLES differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held_p2 <= '0;
         for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            if (sync_p1[i] == held_p2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               held_p2[i] <= ~held_p2[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int HW = $clog2(REPEAT_DELAY + 1);

   logic [HW-1:0] hold_cnt [4];
   logic [3:0]    repeat_fire;

   // Reaching REPEAT_DELAY fires a repeat and rewinds so the next one lands REPEAT_PERIOD later
   function automatic logic [HW-1:0] next_hold(input logic [HW-1:0] c);
      if (c == HW'(REPEAT_DELAY)) return HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      else                        return c + HW'(1);
   endfunction

   always_comb begin
      repeat_fire = '0;
      for (int i = 0; i < 4; i++)
         repeat_fire[i] = held_p2[i] && (hold_cnt[i] == HW'(REPEAT_DELAY));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            hold_cnt[i] <= held_p2[i] ? next_hold(hold_cnt[i]) : '0;
      end
   end

   assign fire_vec = {3'b000, repeat_fire};
`else
   assign fire_vec = '0;
`endif

   // Stage p3: registered press pulses on held rising edges (plus repeats)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held_d_p2 <= '0;
         pulse_p3  <= '0;
      end else begin
         held_d_p2 <= held_p2;
         pulse_p3  <= (held_p2 & ~held_d_p2) | fire_vec;
      end
   end

   assign btn.btn_held     = held_p2;
   assign btn.up_button    = pulse_p3[0];
   assign btn.down_button  = pulse_p3[1];
   assign btn.left_button  = pulse_p3[2];
   assign btn.right_button = pulse_p3[3];
   assign btn.start_button = pulse_p3[4];
   assign btn.a_button     = pulse_p3[5];
   assign btn.b_button     = pulse_p3[6];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   button_if bus ();

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .btn  (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] pulses;
   assign pulses = {bus.b_button, bus.a_button, bus.start_button, bus.right_button,
                    bus.left_button, bus.down_button, bus.up_button};

`ifdef BUTTON_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit right_exp(input int k);
      if (k == 7) return 1'b1;
      if (!AR) return 1'b0;
      return (k == 27 || k == 35 || k == 43 || k == 51 || k == 59);
   endfunction

   initial begin
      bus.btn_raw = 7'h7F;
      reset       = 1'b1;
      #1;
      check_eq("rst_held_async", 32'(bus.btn_held), 32'h0);
      repeat (3) step();
      check_eq("rst_held", 32'(bus.btn_held), 32'h0);
      check_eq("rst_pulses", 32'(pulses), 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check_eq("idle_pulses", 32'(pulses), 32'h0);
         check_eq("idle_held", 32'(bus.btn_held), 32'h0);
      end

      // Clean press on up
      step();
      for (int k = 0; k < 16; k++) begin
         bus.btn_raw[0] = (k >= 10);
         #1;
         check_eq($sformatf("up_pulse_c%0d", k), 32'(bus.up_button), 32'(k == 7));
         check_eq($sformatf("up_held_c%0d", k), 32'(bus.btn_held[0]), 32'(k >= 6));
         check_eq("up_others", 32'(pulses[6:1]), 32'h0);
         step();
      end
      repeat (6) step();
      check_eq("up_released", 32'(bus.btn_held), 32'h0);

      // Bouncing a button never gets accepted
      for (int k = 0; k < 20; k++) begin
         bus.btn_raw[5] = (k < 12) ? 1'((k / 2) % 2) : 1'b1;
         #1;
         check_eq($sformatf("bounce_a_c%0d", k), 32'({bus.a_button, bus.btn_held[5]}), 32'h0);
         step();
      end
      repeat (4) step();

      // Simultaneous start + b
      for (int k = 0; k < 16; k++) begin
         bus.btn_raw[4] = (k >= 10);
         bus.btn_raw[6] = (k >= 10);
         #1;
         check_eq($sformatf("start_c%0d", k), 32'(bus.start_button), 32'(k == 7));
         check_eq($sformatf("b_c%0d", k), 32'(bus.b_button), 32'(k == 7));
         step();
      end
      repeat (10) step();
      check_eq("sim_released", 32'(bus.btn_held), 32'h0);

      // Long hold on right
      for (int k = 0; k < 80; k++) begin
         bus.btn_raw[3] = (k >= 60);
         #1;
         check_eq($sformatf("right_c%0d", k), 32'(bus.right_button), 32'(right_exp(k)));
         step();
      end
      repeat (4) step();

      // Reset during a held down press
      for (int k = 0; k < 26; k++) begin
         bus.btn_raw[1] = (k >= 25);
         if (k == 5) reset = 1'b1;
         if (k == 8) reset = 1'b0;
         #1;
         check_eq($sformatf("down_c%0d", k), 32'(bus.down_button), 32'(k == 15));
         if (k >= 5 && k < 8) begin
            check_eq("rst_mid_held", 32'(bus.btn_held), 32'h0);
            check_eq("rst_mid_pulses", 32'(pulses), 32'h0);
         end
         step();
      end
      repeat (12) step();
      check_eq("final_held", 32'(bus.btn_held), 32'h0);
      check_eq("final_pulses", 32'(pulses), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
